buffer_gearbox: RTL and testbench

Handshaked width-converting shift buffer: accepts narrow slices (for example RMII dibits or nibbles) on a valid/ready stream and packs them into full-width words on a second valid/ready stream. It is the parametrised successor of the plain shift buffer. It adds backpressure, configurable slice placement, partial-word flush on `s_last`, and a per-word slice count. It sits between the PHY-side receive path and the byte/word-oriented frame logic.

---
 rtl/gearbox_pkg.sv | 30 +++
 rtl/gearbox_accum.sv | 69 ++++++
 rtl/buffer_gearbox.sv | 83 ++++++++
 tb/tb_buffer_gearbox.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_pkg.sv
// Shared definitions for the width-converting shift buffer: beat
// classification and slice placement arithmetic.
package gearbox_pkg;

  // What an input cycle does to the accumulator.
  typedef enum logic [1:0] {
    BEAT_IDLE     = 2'd0,  // no slice accepted
    BEAT_STORE    = 2'd1,  // slice accepted, word still open
    BEAT_COMPLETE = 2'd2   // slice accepted and it closes the word
  } beat_e;

  // Bit offset of the least significant bit of slice number idx inside the
  // packed word. With reverse clear the first slice lands at the top of the
  // word; with reverse set it lands at the bottom.
  function automatic int unsigned slice_lsb(input int unsigned idx,
                                            input int unsigned input_size,
                                            input int unsigned buffer_size,
                                            input bit          reverse);
    if (reverse) begin
      return idx * input_size;
    end
    return buffer_size - (idx + 1) * input_size;
  endfunction

  // Width needed to hold a slice count from 0 up to and including slices.
  function automatic int unsigned cnt_width(input int unsigned slices);
    return $clog2(slices + 1);
  endfunction

endpackage

// File: rtl/gearbox_accum.sv
// Accumulator for a partially filled word: stores the slices received so far,
// tracks how many there are, and presents the zero-padded candidate word that
// results from adding the slice currently on the input.
module gearbox_accum
  import gearbox_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned INPUT_SIZE  = 2,
  parameter bit          REVERSE     = 1'b0,
  localparam int unsigned SLICES     = BUFFER_SIZE / INPUT_SIZE,
  localparam int unsigned CNT_W      = cnt_width(SLICES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  beat_e                  beat,
  input  logic [INPUT_SIZE-1:0]  s_data,
  output logic [BUFFER_SIZE-1:0] word,
  output logic [CNT_W-1:0]       cnt
);

  // Slices already received for the open word. The slot of the last slice is
  // never written here because that slice always completes the word.
  logic [BUFFER_SIZE-1:0] acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BUFFER_SIZE-1:0] placed;

  assign cnt = cnt_q;

  // Place the incoming slice at the position selected by the fill counter and
  // merge it with the stored slices; positions not yet filled stay zero.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    placed = '0;
    for (int unsigned i = 0; i < SLICES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        placed[slice_lsb(i, INPUT_SIZE, BUFFER_SIZE, REVERSE) +: INPUT_SIZE] = s_data;
      end
    end
    word = acc_q | placed;
  end

  // Grow the open word on a storing beat; start over after a completing beat.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register updates from the values present before the clock edge.
    if (rst_in) begin
      // NOTE: the accumulator is a plain register, not a memory array, so it is
      // reset with the rest of the state; a discarded partial word must never
      // leak into the zero padding of the next word.
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (beat)
        BEAT_STORE: begin
          acc_q <= word;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        BEAT_COMPLETE: begin
          acc_q <= '0;
          cnt_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/buffer_gearbox.sv
// Handshaked width converter: packs narrow input slices into full-width words
// with backpressure, configurable slice order and partial-word flush on s_last.
module buffer_gearbox
  import gearbox_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned INPUT_SIZE  = 2,
  parameter bit          REVERSE     = 1'b0,
  localparam int unsigned SLICES     = BUFFER_SIZE / INPUT_SIZE,
  localparam int unsigned CNT_W      = cnt_width(SLICES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [INPUT_SIZE-1:0]  s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [BUFFER_SIZE-1:0] m_data,
  output logic [CNT_W-1:0]       m_count,
  output logic                   m_last
);

  // Reject geometries where the word cannot be built from whole slices.
  if (INPUT_SIZE == 0) begin : g_bad_input_size
    $error("buffer_gearbox: INPUT_SIZE must be non-zero");
  end else if (BUFFER_SIZE == 0 || (BUFFER_SIZE % INPUT_SIZE) != 0) begin : g_bad_buffer_size
    $error("buffer_gearbox: BUFFER_SIZE must be a non-zero multiple of INPUT_SIZE");
  end

  logic                   accept;
  logic                   word_end;
  beat_e                  beat;
  logic [BUFFER_SIZE-1:0] cand_word;
  logic [CNT_W-1:0]       cnt;

  // The source may push whenever the output register is empty or is being
  // drained this cycle; this never looks at the input side.
  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign word_end = (cnt == CNT_W'(SLICES - 1)) || s_last;

  // Classify this cycle for the accumulator and the output register.
  always_comb begin
    beat = BEAT_IDLE;
    if (accept) begin
      beat = word_end ? BEAT_COMPLETE : BEAT_STORE;
    end
  end

  gearbox_accum #(
    .BUFFER_SIZE(BUFFER_SIZE),
    .INPUT_SIZE (INPUT_SIZE),
    .REVERSE    (REVERSE)
  ) u_accum (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .beat  (beat),
    .s_data(s_data),
    .word  (cand_word),
    .cnt   (cnt)
  );

  // Output holding register: load a finished word, otherwise hold it until it
  // is consumed. A load in the same cycle as a consume keeps m_valid high.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
      m_last  <= 1'b0;
    end else if (beat == BEAT_COMPLETE) begin
      m_valid <= 1'b1;
      m_data  <= cand_word;
      m_count <= cnt + CNT_W'(1);
      m_last  <= s_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buffer_gearbox.sv
// Self-checking bench for buffer_gearbox: directed scenarios plus a randomized
// run, compared against a queue-based model of words built from slices.
module tb_buffer_gearbox;

  logic       clk;
  logic       rst_in;

  // Shared stream driving the 8/2 instances (first-slice-MSB and -LSB).
  logic       s_valid;
  logic [1:0] s_data;
  logic       s_last;
  logic       m_ready;

  logic       s_ready,   r_s_ready;
  logic       m_valid,   r_m_valid;
  logic [7:0] m_data,    r_m_data;
  logic [2:0] m_count,   r_m_count;
  logic       m_last,    r_m_last;

  // 8/8 instance: every slice is a whole word.
  logic       w_s_valid;
  logic [7:0] w_s_data;
  logic       w_s_last;
  logic       w_m_ready;
  logic       w_s_ready;
  logic       w_m_valid;
  logic [7:0] w_m_data;
  logic [0:0] w_m_count;
  logic       w_m_last;

  int n_checks = 0;
  int n_errors = 0;

  buffer_gearbox #(.BUFFER_SIZE(8), .INPUT_SIZE(2), .REVERSE(1'b0)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
    .m_last(m_last)
  );

  buffer_gearbox #(.BUFFER_SIZE(8), .INPUT_SIZE(2), .REVERSE(1'b1)) dut_rev (
    .clk_in(clk), .rst_in(rst_in),
    .s_valid(s_valid), .s_ready(r_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(r_m_valid), .m_ready(m_ready), .m_data(r_m_data), .m_count(r_m_count),
    .m_last(r_m_last)
  );

  buffer_gearbox #(.BUFFER_SIZE(8), .INPUT_SIZE(8), .REVERSE(1'b0)) dut_wide (
    .clk_in(clk), .rst_in(rst_in),
    .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data), .s_last(w_s_last),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .m_count(w_m_count),
    .m_last(w_m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A word is the list of slices accepted since the last word closed; it is
  // emitted once it holds four slices or a slice arrives with s_last.
  typedef struct {
    logic [7:0] fwd;    // first slice in the top bits
    logic [7:0] rev;    // first slice in the bottom bits
    int         count;
    bit         last;
  } word_t;

  word_t out_q[$];   // finished words not yet consumed (front is on the port)
  int    part_q[$];  // slices of the open word, oldest first
  bit    accepted;   // the last tick accepted a slice

  function automatic word_t pack_word(input bit last);
    word_t w;
    w.fwd   = '0;
    w.rev   = '0;
    w.count = part_q.size();
    w.last  = last;
    for (int k = 0; k < part_q.size(); k++) begin
      w.fwd = w.fwd | (8'(part_q[k] & 3) << (6 - 2 * k));
      w.rev = w.rev | (8'(part_q[k] & 3) << (2 * k));
    end
    return w;
  endfunction

  // One clock cycle of the 8/2 pair: inputs were set after the falling edge;
  // compare the ports against the model, advance the model, step the clock.
  task automatic tick();
    bit exp_ready;
    #1;
    exp_ready = (out_q.size() == 0) || m_ready;
    check("s_ready", s_ready, exp_ready);
    check("rev s_ready", r_s_ready, exp_ready);
    check("m_valid", m_valid, out_q.size() != 0);
    check("rev m_valid", r_m_valid, out_q.size() != 0);
    if (out_q.size() != 0) begin
      check("m_data", m_data, out_q[0].fwd);
      check("rev m_data", r_m_data, out_q[0].rev);
      check("m_count", m_count, out_q[0].count);
      check("rev m_count", r_m_count, out_q[0].count);
      check("m_last", m_last, out_q[0].last);
      check("rev m_last", r_m_last, out_q[0].last);
    end
    accepted = 1'b0;
    if (rst_in) begin
      out_q.delete();
      part_q.delete();
    end else begin
      if (out_q.size() != 0 && m_ready) void'(out_q.pop_front());
      if (s_valid && exp_ready) begin
        accepted = 1'b1;
        part_q.push_back(int'(s_data));
        if (part_q.size() == 4 || s_last) begin
          out_q.push_back(pack_word(s_last));
          part_q.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one slice and keep offering it until accepted (bounded).
  task automatic send(input logic [1:0] d, input bit last);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (accepted) begin
        ok = 1'b1;
        break;
      end
    end
    check("send accepted within bound", ok, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    logic [1:0] stall_seq [8];
    int         idx;

    rst_in    = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    w_s_valid = 1'b0;
    w_s_data  = '0;
    w_s_last  = 1'b0;
    w_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    #1;

    // Reset state.
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset m_count", m_count, 0);
    check("reset m_last", m_last, 0);
    check("reset s_ready", s_ready, 1);
    check("reset cnt", dut.cnt, 0);
    check("reset wide m_valid", w_m_valid, 0);
    @(negedge clk);

    // Single-slice words: A5 then 3C on consecutive cycles.
    w_s_valid = 1'b1;
    w_s_data  = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    w_s_data = 8'h3C;
    #1;
    check("wide w1 valid", w_m_valid, 1);
    check("wide w1 data", w_m_data, 8'hA5);
    check("wide w1 count", w_m_count, 1);
    check("wide w1 last", w_m_last, 0);
    check("wide s_ready", w_s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    w_s_valid = 1'b0;
    #1;
    check("wide w2 valid", w_m_valid, 1);
    check("wide w2 data", w_m_data, 8'h3C);
    check("wide w2 count", w_m_count, 1);
    @(posedge clk);
    @(negedge clk);
    check("wide drained", w_m_valid, 0);

    // Full word, consecutive slices 01,10,11,00.
    send(2'b01, 0);
    send(2'b10, 0);
    send(2'b11, 0);
    send(2'b00, 0);
    #1;
    check("t1 m_valid", m_valid, 1);
    check("t1 m_data", m_data, 8'h6C);
    check("t1 rev m_data", r_m_data, 8'h39);
    check("t1 m_count", m_count, 4);
    check("t1 m_last", m_last, 0);
    tick();
    check("t1 single cycle valid", m_valid, 0);

    // Short word flushed by s_last, then a fresh word from slot 0.
    send(2'b11, 0);
    send(2'b01, 1);
    #1;
    check("t3 m_data", m_data, 8'hD0);
    check("t3 rev m_data", r_m_data, 8'h07);
    check("t3 m_count", m_count, 2);
    check("t3 m_last", m_last, 1);
    tick();
    check("t3 cnt restart", dut.cnt, 0);
    send(2'b10, 0);
    send(2'b00, 0);
    send(2'b01, 0);
    send(2'b11, 0);
    #1;
    check("t3 next word", m_data, 8'h87);
    tick();

    // Backpressure: eight slices with m_ready low until cycle 10.
    stall_seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11};
    m_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      s_valid = 1'b1;
      s_data  = stall_seq[idx];
      s_last  = 1'b0;
      if (cyc == 8) begin
        #1;
        check("t4 held m_data", m_data, 8'h6C);
        check("t4 held s_ready", s_ready, 0);
        check("t4 held cnt", dut.cnt, 0);
      end
      if (cyc == 10) m_ready = 1'b1;
      tick();
      if (accepted) idx++;
    end
    s_valid = 1'b0;
    check("t4 all slices accepted", idx, 8);
    #1;
    check("t4 second word", m_data, 8'h93);
    check("t4 second count", m_count, 4);
    tick();
    check("t4 drained", m_valid, 0);

    // Reset mid-word discards the partial word.
    send(2'b01, 0);
    send(2'b10, 0);
    send(2'b11, 0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    #1;
    check("t5 m_valid after reset", m_valid, 0);
    check("t5 cnt after reset", dut.cnt, 0);
    send(2'b11, 0);
    send(2'b11, 0);
    send(2'b00, 0);
    send(2'b01, 0);
    #1;
    check("t5 clean word", m_data, 8'hF1);
    check("t5 clean count", m_count, 4);
    tick();

    // Randomized traffic with random backpressure, flushes and resets.
    accepted = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!s_valid || accepted) begin
        s_valid = ($urandom % 4) != 0;
        s_data  = 2'($urandom);
        s_last  = ($urandom % 6) == 0;
      end
      m_ready = ($urandom % 3) != 0;
      rst_in  = ($urandom % 250) == 0;
      tick();
    end
    rst_in  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
